head_table_wr_arb: RTL and testbench

- Owns the write port of the head table RAM; is the single driver of wr_addr/wr_data/wr_en on the head table write interface.
- Shares that port between N_REQ write requesters (insert engine, delete engine, ...) using round-robin arbitration.
- Sequences the OP_INIT sweep, which clears every bucket (ptr_val=0) at one address per cycle while all requesters are stalled.

---
 rtl/head_table_wr_arb_if.sv | 29 ++
 rtl/head_table_wr_arb.sv | 125 ++++++++++++
 tb/tb_head_table_wr_arb.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/head_table_wr_arb_if.sv
// Head table write-port bundle: requester handshakes, init control and RAM write port.
interface head_table_wr_arb_if #(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned A_WIDTH = 8,
  parameter int unsigned D_WIDTH = 11
) ();

  logic                       init_start_i;
  logic                       init_busy_o;
  logic                       init_done_o;
  logic [N_REQ-1:0]           req_valid_i;
  logic [N_REQ*A_WIDTH-1:0]   req_addr_i;
  logic [N_REQ*D_WIDTH-1:0]   req_data_i;
  logic [N_REQ-1:0]           req_ready_o;
  logic [A_WIDTH-1:0]         wr_addr_o;
  logic [D_WIDTH-1:0]         wr_data_o;
  logic                       wr_en_o;

  modport slave (
    input  init_start_i, req_valid_i, req_addr_i, req_data_i,
    output init_busy_o, init_done_o, req_ready_o, wr_addr_o, wr_data_o, wr_en_o
  );

  modport master (
    output init_start_i, req_valid_i, req_addr_i, req_data_i,
    input  init_busy_o, init_done_o, req_ready_o, wr_addr_o, wr_data_o, wr_en_o
  );

endinterface

// File: rtl/head_table_wr_arb.sv
// Single owner of the head table write port: round-robin arbitration between
// write requesters, plus the init sweep that clears every bucket.
module head_table_wr_arb #(
  parameter int unsigned         N_REQ     = 2,
  parameter int unsigned         A_WIDTH   = 8,
  parameter int unsigned         D_WIDTH   = 11,
  parameter logic [D_WIDTH-1:0]  INIT_DATA = '0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  head_table_wr_arb_if.slave  bus
);

  localparam int unsigned        PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [A_WIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t               state_q, state_d;
  logic [A_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic                 wr_en_q, wr_en_d;
  logic [A_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [D_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [N_REQ-1:0]     ready_c;
  logic                 gnt_found;
  logic [PTR_W-1:0]     gnt_idx;
  int                   idx;

  // Round-robin search starting just after the last granted requester
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= int'(N_REQ); k++) begin
      idx = (int'(ptr_q) + k) % int'(N_REQ);
      if (!gnt_found && bus.req_valid_i[idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    ready_c   = '0;
    unique case (state_q)
      IDLE: begin
        if (bus.init_start_i) begin
          // Init wins over any pending request; address 0 goes out next cycle
          state_d   = SWEEP;
          busy_d    = 1'b1;
          cnt_d     = '0;
          wr_en_d   = 1'b1;
          wr_addr_d = '0;
          wr_data_d = INIT_DATA;
        end else if (gnt_found) begin
          ready_c[gnt_idx] = 1'b1;
          ptr_d     = gnt_idx;
          wr_en_d   = 1'b1;
          wr_addr_d = bus.req_addr_i[int'(gnt_idx)*A_WIDTH +: A_WIDTH];
          wr_data_d = bus.req_data_i[int'(gnt_idx)*D_WIDTH +: D_WIDTH];
        end
      end
      SWEEP: begin
        // cnt_q tracks the address currently presented on the write port
        if (cnt_q == LAST_ADDR) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d     = cnt_q + A_WIDTH'(1);
          wr_en_d   = 1'b1;
          wr_addr_d = cnt_q + A_WIDTH'(1);
          wr_data_d = INIT_DATA;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= PTR_W'(N_REQ - 1);
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.req_ready_o = ready_c;
  assign bus.wr_en_o     = wr_en_q;
  assign bus.wr_addr_o   = wr_addr_q;
  assign bus.wr_data_o   = wr_data_q;
  assign bus.init_busy_o = busy_q;
  assign bus.init_done_o = done_q;

  ready_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(ready_c));
  no_ready_when_busy: assert property (@(posedge clk_i) disable iff (rst_i) !(busy_q && (|ready_c)));

endmodule

// File: tb/tb_head_table_wr_arb.sv
// Directed bench for head_table_wr_arb: single write, round robin, init sweep,
// init/request collision, ignored re-init and reset mid-sweep.
module tb_head_table_wr_arb;

  localparam int unsigned N_REQ   = 2;
  localparam int unsigned A_WIDTH = 8;
  localparam int unsigned D_WIDTH = 11;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;

  head_table_wr_arb_if #(.N_REQ(N_REQ), .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH)) bus ();

  head_table_wr_arb #(
    .N_REQ(N_REQ), .A_WIDTH(A_WIDTH), .D_WIDTH(D_WIDTH), .INIT_DATA('0)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst                = 1'b1;
    bus.init_start_i   = 1'b0;
    bus.req_valid_i    = '0;
    bus.req_addr_i     = '0;
    bus.req_data_i     = '0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_wr_en", 32'(bus.wr_en_o), 32'h0);
    chk("rst_wr_addr", 32'(bus.wr_addr_o), 32'h0);
    chk("rst_wr_data", 32'(bus.wr_data_o), 32'h0);
    chk("rst_busy", 32'(bus.init_busy_o), 32'h0);
    chk("rst_done", 32'(bus.init_done_o), 32'h0);
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    rst = 1'b0;

    // Single requester write
    @(negedge clk);
    bus.req_valid_i = 2'b01;
    bus.req_addr_i  = {8'h00, 8'h12};
    bus.req_data_i  = {11'h000, 11'h405};
    #1 chk("t1_ready", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #1;
    chk("t1_wr_en", 32'(bus.wr_en_o), 32'h1);
    chk("t1_wr_addr", 32'(bus.wr_addr_o), 32'h12);
    chk("t1_wr_data", 32'(bus.wr_data_o), 32'h405);
    chk("t1_ready_idle", 32'(bus.req_ready_o), 32'h0);
    @(negedge clk);
    #1;
    chk("t1_wr_en_off", 32'(bus.wr_en_o), 32'h0);
    chk("t1_addr_hold", 32'(bus.wr_addr_o), 32'h12);

    // Reset pulse so round robin starts from requester 0
    rst = 1'b1;
    #1 chk("rst2_wr_addr", 32'(bus.wr_addr_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Round robin, both valid for 6 cycles
    @(negedge clk);
    bus.req_valid_i = 2'b11;
    bus.req_addr_i  = {8'h02, 8'h01};
    bus.req_data_i  = {11'h022, 11'h011};
    for (int k = 0; k < 6; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      chk("rr_ready", 32'(bus.req_ready_o), (k % 2 == 0) ? 32'h1 : 32'h2);
      if (k > 0) begin
        chk("rr_wr_en", 32'(bus.wr_en_o), 32'h1);
        chk("rr_wr_addr", 32'(bus.wr_addr_o), (k % 2 == 1) ? 32'h01 : 32'h02);
      end
    end
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #1;
    chk("rr_last_wr_en", 32'(bus.wr_en_o), 32'h1);
    chk("rr_last_addr", 32'(bus.wr_addr_o), 32'h02);
    chk("rr_last_data", 32'(bus.wr_data_o), 32'h022);

    // Full init sweep with both requesters valid throughout
    @(negedge clk);
    bus.init_start_i = 1'b1;
    bus.req_valid_i  = 2'b11;
    #1;
    chk("sw_start_ready", 32'(bus.req_ready_o), 32'h0);
    chk("sw_start_busy", 32'(bus.init_busy_o), 32'h0);
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      bus.init_start_i = 1'b0;
      #1;
      chk("sw_wr_en", 32'(bus.wr_en_o), 32'h1);
      chk("sw_wr_addr", 32'(bus.wr_addr_o), 32'(c));
      chk("sw_wr_data", 32'(bus.wr_data_o), 32'h0);
      chk("sw_busy", 32'(bus.init_busy_o), 32'h1);
      chk("sw_done", 32'(bus.init_done_o), 32'h0);
      chk("sw_ready", 32'(bus.req_ready_o), 32'h0);
    end
    @(negedge clk);
    #1;
    chk("sw_done_pulse", 32'(bus.init_done_o), 32'h1);
    chk("sw_done_busy", 32'(bus.init_busy_o), 32'h0);
    chk("sw_done_wr_en", 32'(bus.wr_en_o), 32'h0);
    chk("sw_done_ready", 32'(bus.req_ready_o), 32'h1);
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #1;
    chk("sw_post_wr_en", 32'(bus.wr_en_o), 32'h1);
    chk("sw_post_addr", 32'(bus.wr_addr_o), 32'h01);
    chk("sw_post_data", 32'(bus.wr_data_o), 32'h011);
    chk("sw_post_done", 32'(bus.init_done_o), 32'h0);

    // Init colliding with req1, plus a re-init at address 0x40 that must be ignored
    @(negedge clk);
    bus.init_start_i = 1'b1;
    bus.req_valid_i  = 2'b10;
    bus.req_addr_i   = {8'h33, 8'h01};
    bus.req_data_i   = {11'h155, 11'h011};
    #1 chk("col_ready", 32'(bus.req_ready_o), 32'h0);
    done_cnt = 0;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      bus.init_start_i = (c == 8'h40);
      #1;
      chk("col_wr_addr", 32'(bus.wr_addr_o), 32'(c));
      chk("col_wr_en", 32'(bus.wr_en_o), 32'h1);
      chk("col_sw_ready", 32'(bus.req_ready_o), 32'h0);
      if (bus.init_done_o) done_cnt++;
    end
    @(negedge clk);
    bus.init_start_i = 1'b0;
    #1;
    chk("col_done", 32'(bus.init_done_o), 32'h1);
    chk("col_grant1", 32'(bus.req_ready_o), 32'h2);
    chk("col_busy", 32'(bus.init_busy_o), 32'h0);
    if (bus.init_done_o) done_cnt++;
    @(negedge clk);
    bus.req_valid_i = 2'b00;
    #1;
    chk("col_wr_en", 32'(bus.wr_en_o), 32'h1);
    chk("col_wr_addr1", 32'(bus.wr_addr_o), 32'h33);
    chk("col_wr_data1", 32'(bus.wr_data_o), 32'h155);
    if (bus.init_done_o) done_cnt++;
    @(negedge clk);
    #1;
    chk("col_idle_wr_en", 32'(bus.wr_en_o), 32'h0);
    chk("col_idle_busy", 32'(bus.init_busy_o), 32'h0);
    if (bus.init_done_o) done_cnt++;
    chk("col_done_count", 32'(done_cnt), 32'h1);

    // Reset in the middle of a sweep, then a fresh sweep from address 0
    @(negedge clk);
    bus.init_start_i = 1'b1;
    for (int c = 0; c <= 8'h80; c++) begin
      @(negedge clk);
      bus.init_start_i = 1'b0;
    end
    #1;
    chk("mid_addr", 32'(bus.wr_addr_o), 32'h80);
    chk("mid_busy", 32'(bus.init_busy_o), 32'h1);
    rst = 1'b1;
    #1;
    chk("mid_rst_wr_en", 32'(bus.wr_en_o), 32'h0);
    chk("mid_rst_busy", 32'(bus.init_busy_o), 32'h0);
    chk("mid_rst_addr", 32'(bus.wr_addr_o), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      chk("mid_quiet_done", 32'(bus.init_done_o), 32'h0);
      chk("mid_quiet_wr_en", 32'(bus.wr_en_o), 32'h0);
    end
    @(negedge clk);
    bus.init_start_i = 1'b1;
    for (int c = 0; c < 256; c++) begin
      @(negedge clk);
      bus.init_start_i = 1'b0;
      #1;
      chk("re_wr_addr", 32'(bus.wr_addr_o), 32'(c));
      chk("re_wr_en", 32'(bus.wr_en_o), 32'h1);
    end
    @(negedge clk);
    #1;
    chk("re_done", 32'(bus.init_done_o), 32'h1);
    chk("re_busy", 32'(bus.init_busy_o), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
